// File: rtl/katana_tracker.sv
// katana_tracker: conditions raw per-frame centre-of-mass results into a
// smoothed katana position. EMA smoothing, acquire/track/lost FSM with
// dropout hold, and per-update L1 speed with a slice strobe.
module katana_tracker #(
   parameter int ALPHA_SHIFT  = 2,
   parameter int ACQ_FRAMES   = 3,
   parameter int MISS_LIMIT   = 4,
   parameter int SLICE_THRESH = 64
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [10:0] x_in,
   input  logic [9:0]  y_in,
   input  logic        valid_in,
   input  logic        frame_start_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic        valid_out,
   output logic        tracking_out,
   output logic [11:0] speed_out,
   output logic        slice_out
);

   localparam int ACC_XW = 11 + ALPHA_SHIFT;
   localparam int ACC_YW = 10 + ALPHA_SHIFT;
   localparam int CW     = 8;

   typedef enum logic [1:0] {ST_LOST, ST_ACQUIRE, ST_TRACK} state_t;

   state_t              r_state;
   logic [CW-1:0]       r_acq_cnt;
   logic [CW-1:0]       r_miss_cnt;
   logic                r_got_sample;
   logic                r_tracking;

   logic                r_s1_valid;
   logic                r_s1_load;
   logic [10:0]         r_s1_x;
   logic [9:0]          r_s1_y;
   logic                r_s2_valid;
   logic                r_s2_load;
   logic [ACC_XW-1:0]   r_acc_x;
   logic [ACC_YW-1:0]   r_acc_y;

   logic [10:0]         r_x_out;
   logic [9:0]          r_y_out;
   logic                r_valid_out;
   logic [11:0]         r_speed;
   logic                r_slice;

   logic                w_frame_hit;
   logic [10:0]         w_x_new;
   logic [9:0]          w_y_new;
   logic [10:0]         w_dx_abs;
   logic [9:0]          w_dy_abs;
   logic [11:0]         w_speed;
   logic                w_s3_en;

   // A sample arriving on the frame-start cycle still belongs to the closing frame
   assign w_frame_hit = r_got_sample | valid_in;

   // Tracking FSM: acquire counts frames with samples, track counts misses
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= ST_LOST;
         r_acq_cnt    <= '0;
         r_miss_cnt   <= '0;
         r_got_sample <= 1'b0;
         r_tracking   <= 1'b0;
      end else begin
         r_tracking <= (r_state == ST_TRACK);
         if (frame_start_in)
            r_got_sample <= 1'b0;
         else if (valid_in)
            r_got_sample <= 1'b1;
         case (r_state)
            ST_LOST: begin
               if (valid_in) begin
                  r_state    <= ST_ACQUIRE;
                  r_acq_cnt  <= CW'(1);
                  r_miss_cnt <= '0;
               end
            end
            ST_ACQUIRE: begin
               // acq_cnt counts the frames with a sample including the one closing now
               if (frame_start_in) begin
                  if (!w_frame_hit) begin
                     r_state <= ST_LOST;
                  end else if (r_acq_cnt >= CW'(ACQ_FRAMES)) begin
                     r_state    <= ST_TRACK;
                     r_miss_cnt <= '0;
                  end else begin
                     r_acq_cnt <= r_acq_cnt + 1'b1;
                  end
               end
            end
            ST_TRACK: begin
               if (frame_start_in) begin
                  if (w_frame_hit) begin
                     r_miss_cnt <= '0;
                  end else if (r_miss_cnt + 1'b1 == CW'(MISS_LIMIT)) begin
                     r_state    <= ST_LOST;
                     r_miss_cnt <= '0;
                  end else begin
                     r_miss_cnt <= r_miss_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= ST_LOST;
         endcase
      end
   end

   // New smoothed position and L1 distance from the last published one
   always_comb begin
      w_x_new  = r_acc_x[ACC_XW-1:ALPHA_SHIFT];
      w_y_new  = r_acc_y[ACC_YW-1:ALPHA_SHIFT];
      w_dx_abs = (w_x_new >= r_x_out) ? (w_x_new - r_x_out) : (r_x_out - w_x_new);
      w_dy_abs = (w_y_new >= r_y_out) ? (w_y_new - r_y_out) : (r_y_out - w_y_new);
      w_speed  = {1'b0, w_dx_abs} + {2'b00, w_dy_abs};
      // While LOST only the re-acquiring load sample may be published
      w_s3_en  = r_s2_valid & (r_s2_load | (r_state != ST_LOST));
   end

   // Three-stage datapath: capture, accumulate, publish
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_s1_valid  <= 1'b0;
         r_s1_load   <= 1'b0;
         r_s1_x      <= '0;
         r_s1_y      <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_load   <= 1'b0;
         r_acc_x     <= '0;
         r_acc_y     <= '0;
         r_x_out     <= '0;
         r_y_out     <= '0;
         r_valid_out <= 1'b0;
         r_speed     <= '0;
         r_slice     <= 1'b0;
      end else begin
         r_s1_valid <= valid_in;
         r_s1_load  <= (r_state == ST_LOST);
         r_s1_x     <= x_in;
         r_s1_y     <= y_in;

         r_s2_valid <= r_s1_valid;
         r_s2_load  <= r_s1_load;
         if (r_s1_valid) begin
            if (r_s1_load) begin
               r_acc_x <= ACC_XW'(r_s1_x) << ALPHA_SHIFT;
               r_acc_y <= ACC_YW'(r_s1_y) << ALPHA_SHIFT;
            end else begin
               r_acc_x <= r_acc_x - (r_acc_x >> ALPHA_SHIFT) + ACC_XW'(r_s1_x);
               r_acc_y <= r_acc_y - (r_acc_y >> ALPHA_SHIFT) + ACC_YW'(r_s1_y);
            end
         end

         r_valid_out <= w_s3_en;
         r_slice     <= w_s3_en & ~r_s2_load & (r_state == ST_TRACK) &
                        (w_speed >= 12'(SLICE_THRESH));
         if (w_s3_en) begin
            r_x_out <= w_x_new;
            r_y_out <= w_y_new;
            r_speed <= r_s2_load ? 12'd0 : w_speed;
         end
      end
   end

   assign x_out        = r_x_out;
   assign y_out        = r_y_out;
   assign valid_out    = r_valid_out;
   assign tracking_out = r_tracking;
   assign speed_out    = r_speed;
   assign slice_out    = r_slice;

endmodule
